// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// FSM state encoding, active-high glyph table {g,f,e,d,c,b,a}, and the
// output polarity helper.
package seg_display_pkg;

   // Scan FSM states
   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   // Active-high glyphs, index = digit value (0-9, then A b C d E F)
   localparam logic [6:0] GLYPHS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Maps active-high {dp,seg} to the pin polarity of the display
   function automatic logic [7:0] seg_polarity(input logic [7:0] lit, input bit active_low);
      return active_low ? ~lit : lit;
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit value to active-high 7-segment pattern {g,f,e,d,c,b,a}.
// Every input value has a glyph, so the output is never undefined.
module hex_to_7seg
   import seg_display_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] segments
);

   assign segments = GLYPHS[value];

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed 7-segment driver. Each digit slot is one guard cycle
// (anodes off, segments settle) followed by REFRESH_DIV-1 drive cycles.
// All digits are captured together at frame start so a frame never mixes
// old and new values.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg_display_mux
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clockIn,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    blank,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    scan_tick
);

   localparam int DW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [1:0]              state_q, state_d;
   logic [DW-1:0]           div_q, div_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
   logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
   logic [NUM_DIGITS-1:0]   supp_q, supp_d;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    take_snap;
   logic [3:0]              cur_digit;
   logic [6:0]              glyph;
   logic                    lit_on;
   logic [6:0]              seg_lit;
   logic                    dp_lit;
   logic [NUM_DIGITS-1:0]   an_d;

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_run;

   // Mark zeros from the leftmost digit down to the first nonzero; digit 0 always shown
   always_comb begin
      lz_mask = '0;
      lz_run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lz_run && (digits_in[4*i +: 4] == 4'h0)) lz_mask[i] = 1'b1;
         else                                         lz_run     = 1'b0;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Next-state logic for the scan FSM, divider, scan index and snapshot
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      div_d     = div_q;
      idx_d     = idx_q;
      take_snap = 1'b0;
      if (!en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d   = ST_GUARD;
               div_d     = '0;
               idx_d     = '0;
               take_snap = 1'b1;
            end
            ST_GUARD: begin
               state_d = ST_DRIVE;
               div_d   = div_q + 1'b1;
            end
            ST_DRIVE: begin
               if (div_q == DIV_LAST) begin
                  state_d = ST_GUARD;
                  div_d   = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d     = '0;
                     take_snap = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
      snap_d    = take_snap ? digits_in : snap_q;
      dp_snap_d = take_snap ? dp_in     : dp_snap_q;
      supp_d    = take_snap ? lz_mask   : supp_q;
   end

   assign cur_digit = snap_d[{idx_d, 2'b00} +: 4];

   hex_to_7seg u_decode (
      .value    (cur_digit),
      .segments (glyph)
   );

   // Output values for the coming cycle, derived from the next state
   always_comb begin
      lit_on  = en && !blank && (state_d != ST_OFF);
      seg_lit = (lit_on && !supp_d[idx_d]) ? glyph : 7'h00;
      dp_lit  = lit_on && dp_snap_d[idx_d];
      an_d    = '1;
      if (lit_on && (state_d == ST_DRIVE)) an_d[idx_d] = 1'b0;
   end

   // State, snapshot and output registers; reset forces anodes off immediately
   always_ff @(posedge clockIn or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_OFF;
         div_q     <= '0;
         idx_q     <= '0;
         snap_q    <= '0;
         dp_snap_q <= '0;
         supp_q    <= '0;
         an        <= '1;
         {dp, seg} <= seg_polarity(8'h00, SEG_ACTIVE_LOW);
         scan_tick <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every register samples pre-edge values.
         state_q   <= state_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         dp_snap_q <= dp_snap_d;
         supp_q    <= supp_d;
         an        <= an_d;
         {dp, seg} <= seg_polarity({dp_lit, seg_lit}, SEG_ACTIVE_LOW);
         scan_tick <= take_snap;
      end
   end

endmodule
